// File: rtl/fp_norm_pipe.sv
// Two-stage floating-point post-add normaliser: S1 aligns the raw adder sum,
// S2 rounds to nearest-even and saturates overflow. Valid/ready flow control.
module fp_norm_pipe #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic              co,
  input  logic [EW-1:0]     es,
  input  logic [MW+4:0]     ms,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [EW-1:0]     e,
  output logic [MW-1:0]     m,
  output logic              ovf,
  output logic              zero
);

  localparam int MSW = MW + 5;
  localparam int NW  = MW + 4;
  localparam int LZW = $clog2(NW + 1);
  localparam int XW  = ((EW > LZW) ? EW : LZW) + 1;
  localparam logic [EW:0] EMAX = {1'b0, {EW{1'b1}}};

  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q, s1_sign_d;
  logic              s1_zero_q, s1_zero_d;
  logic [EW:0]       s1_exp_q, s1_exp_d;
  logic [NW-1:0]     s1_man_q, s1_man_d;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_sign_q, s2_sign_d;
  logic              s2_zero_q, s2_zero_d;
  logic              s2_ovf_q, s2_ovf_d;
  logic [EW-1:0]     s2_e_q, s2_e_d;
  logic [MW-1:0]     s2_m_q, s2_m_d;

  logic              s2_adv;
  logic [LZW-1:0]    lz;
  logic              lz_found;
  logic [XW-1:0]     es_x, lz_x, sub_sh;
  logic              round_up;
  logic [MW+1:0]     rsum;
  logic [EW:0]       exp_r;
  logic [MW-1:0]     frac_r;
  logic              ovf_r;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  // Leading-zero count over hidden bit and below; NW means the word is all zero.
  always_comb begin
    lz       = LZW'(NW);
    lz_found = 1'b0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (!lz_found && ms[i]) begin
        lz       = LZW'(NW - 1 - i);
        lz_found = 1'b1;
      end
    end
  end

  assign es_x   = XW'(es);
  assign lz_x   = XW'(lz);
  assign sub_sh = (es == '0) ? '0 : (es_x - XW'(1));

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_exp_d   = s1_exp_q;
    s1_man_d   = s1_man_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_valid && in_ready) begin
      s1_sign_d = sign_in;
      s1_zero_d = 1'b0;
      if (co) begin
        s1_man_d = {ms[MSW-1:2], ms[1] | ms[0]};
        s1_exp_d = (EW+1)'(es) + (EW+1)'(1);
      end else if (!lz_found) begin
        s1_man_d  = '0;
        s1_exp_d  = '0;
        s1_zero_d = 1'b1;
      end else if (es_x > lz_x) begin
        s1_man_d = ms[NW-1:0] << lz;
        s1_exp_d = (EW+1)'(es_x - lz_x);
      end else begin
        // Exponent runs out before the hidden bit is reached: denormal result.
        s1_man_d = ms[NW-1:0] << sub_sh;
        s1_exp_d = '0;
      end
    end
  end

  // Round to nearest, ties to even, on guard/round/sticky below the fraction LSB.
  always_comb begin
    round_up = s1_man_q[2] && (s1_man_q[1] || s1_man_q[0] || s1_man_q[3]);
    rsum     = {1'b0, s1_man_q[NW-1:3]} + (MW+2)'(round_up);
    frac_r   = rsum[MW-1:0];
    exp_r    = s1_exp_q;
    if (rsum[MW+1]) begin
      frac_r = '0;
      exp_r  = s1_exp_q + (EW+1)'(1);
    end else if (s1_exp_q == '0 && rsum[MW]) begin
      exp_r = (EW+1)'(1);
    end
    ovf_r = (exp_r >= EMAX);
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    s2_ovf_d   = s2_ovf_q;
    s2_e_d     = s2_e_q;
    s2_m_d     = s2_m_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_adv && s1_valid_q) begin
      s2_sign_d = s1_sign_q;
      s2_zero_d = s1_zero_q;
      s2_ovf_d  = ovf_r;
      s2_e_d    = ovf_r ? {EW{1'b1}} : exp_r[EW-1:0];
      s2_m_d    = ovf_r ? '0 : frac_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_e_q     <= '0;
      s2_m_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_exp_q   <= s1_exp_d;
      s1_man_q   <= s1_man_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_e_q     <= s2_e_d;
      s2_m_q     <= s2_m_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign sign_out  = s2_sign_q;
  assign e         = s2_e_q;
  assign m         = s2_m_q;
  assign ovf       = s2_ovf_q;
  assign zero      = s2_zero_q;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Randomised bench for fp_norm_pipe: arithmetic reference model plus an
// in-order scoreboard, directed corner words, backpressure and reset cases.
module tb_fp_norm_pipe;

  typedef struct packed {
    logic        s;
    logic        co;
    logic [7:0]  es;
    logic [27:0] ms;
  } word_t;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic        co;
  logic [7:0]  es;
  logic [27:0] ms;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  e;
  logic [22:0] m;
  logic        ovf;
  logic        zero;

  int checks = 0;
  int errors = 0;
  int out_n  = 0;

  word_t stim_q[$];
  res_t  exp_q[$];

  fp_norm_pipe #(.EW(8), .MW(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .co        (co),
    .es        (es),
    .ms        (ms),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .e         (e),
    .m         (m),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: value-level normalise then round-to-nearest-even on integers.
  function automatic res_t model(input word_t w);
    longint v, n, q;
    int     ex, lz, r;
    res_t   res;
    res.s    = w.s;
    res.zero = 1'b0;
    res.ovf  = 1'b0;
    n  = 0;
    ex = 0;
    if (w.co) begin
      n  = (longint'(w.ms) >> 1) | (longint'(w.ms) & 1);
      ex = int'(w.es) + 1;
    end else begin
      v = longint'(w.ms) & ((longint'(1) << 27) - 1);
      if (v == 0) begin
        res.zero = 1'b1;
      end else begin
        lz = 0;
        while ((v << lz) < (longint'(1) << 26)) lz++;
        if (int'(w.es) > lz) begin
          n  = v << lz;
          ex = int'(w.es) - lz;
        end else begin
          n  = v << ((w.es > 0) ? int'(w.es) - 1 : 0);
          ex = 0;
        end
      end
    end
    q = n >> 3;
    r = int'(n & 7);
    if (r > 4 || (r == 4 && q[0])) q++;
    if (q >= (longint'(1) << 24)) begin
      ex++;
      q = 0;
    end else if (ex == 0 && q >= (longint'(1) << 23)) begin
      ex = 1;
    end
    if (ex >= 255) begin
      res.e   = 8'hFF;
      res.m   = '0;
      res.ovf = 1'b1;
    end else begin
      res.e = ex[7:0];
      res.m = q[22:0];
    end
    return res;
  endfunction

  function automatic word_t rand_word();
    word_t       w;
    logic [26:0] v;
    w.s  = 1'($urandom);
    w.co = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 3))
      0:       w.es = 8'($urandom_range(0, 6));
      1:       w.es = 8'($urandom_range(248, 255));
      default: w.es = 8'($urandom);
    endcase
    v = 27'($urandom);
    if (w.co) begin
      w.ms = {1'b1, v};
    end else begin
      v = v >> $urandom_range(0, 27);
      if ($urandom_range(0, 15) == 0) v = '0;
      w.ms = {1'b0, v};
    end
    if ($urandom_range(0, 3) == 0) w.ms[2:0] = 3'b100;
    return w;
  endfunction

  task automatic drive(input word_t w);
    sign_in = w.s;
    co      = w.co;
    es      = w.es;
    ms      = w.ms;
  endtask

  task automatic directed(input word_t w, input logic [7:0] xe, input logic [22:0] xm,
                          input logic xovf, input logic xzero);
    res_t want;
    res_t got;
    want = model(w);
    @(negedge clk);
    drive(w);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 check_eq("dir_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    drive(rand_word());
    #1 check_eq("dir_lat1", out_valid, 1'b0);
    @(negedge clk);
    #1 check_eq("dir_lat2", out_valid, 1'b1);
    got = {sign_out, e, m, ovf, zero};
    check_eq("dir_spec", {e, m, ovf, zero}, {xe, xm, xovf, xzero});
    check_eq("dir_sign", sign_out, w.s);
    check_eq("dir_model", got, want);
    $display("dir es=%02h co=%0b ms=%07h -> s=%0b e=%02h m=%06h ovf=%0b zero=%0b",
             w.es, w.co, w.ms, sign_out, e, m, ovf, zero);
  endtask

  // mode 0: random valid/ready; mode 1: out_ready held low for the first 3 cycles.
  task automatic run_stream(input int max_cycles, input int mode);
    word_t cur;
    bit    have;
    bit    stall_prev;
    res_t  held;
    res_t  got;
    res_t  want;
    have       = 0;
    stall_prev = 0;
    cur        = '0;
    held       = '0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      if (stim_q.size() == 0 && !have && exp_q.size() == 0) break;
      @(negedge clk);
      if (!have && stim_q.size() > 0 && (mode == 1 || $urandom_range(0, 3) != 0)) begin
        cur  = stim_q.pop_front();
        have = 1;
      end
      in_valid = have;
      drive(have ? cur : rand_word());
      out_ready = (mode == 1) ? (cyc >= 3) : ($urandom_range(0, 2) != 0);
      #1;
      got = {sign_out, e, m, ovf, zero};
      if (stall_prev) begin
        check_eq("stall_valid", out_valid, 1'b1);
        check_eq("stall_hold", got, held);
      end
      if (mode == 1 && cyc == 2) check_eq("bp_in_ready", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        check_eq("out_has_expect", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          check_eq("result", got, want);
        end
        $display("out #%0d s=%0b e=%02h m=%06h ovf=%0b zero=%0b",
                 out_n, sign_out, e, m, ovf, zero);
        out_n++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(cur));
        have = 0;
      end
      stall_prev = out_valid && !out_ready;
      held       = got;
    end
    check_eq("drain", stim_q.size() + exp_q.size() + int'(have), 0);
    stim_q.delete();
    exp_q.delete();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic reset_mid();
    @(negedge clk);
    drive(rand_word());
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    drive(rand_word());
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(rand_word());
    #1 check_eq("rm_full", out_valid, 1'b1);
    @(negedge clk);
    #1 check_eq("rm_cleared", out_valid, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1 check_eq("rm_in_ready", in_ready, 1'b1);
    repeat (6) begin
      @(negedge clk);
      #1 check_eq("rm_ghost", out_valid, 1'b0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive('0);
    repeat (3) begin
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'($urandom);
      drive(rand_word());
    end
    @(negedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_e", e, 8'h00);
    check_eq("rst_m", m, 23'h0);
    check_eq("rst_sign", sign_out, 1'b0);
    check_eq("rst_ovf", ovf, 1'b0);
    check_eq("rst_zero", zero, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1 check_eq("rst_in_ready", in_ready, 1'b1);

    directed('{s:1'b0, co:1'b0, es:8'h80, ms:28'h4000000}, 8'h80, 23'h0, 1'b0, 1'b0);
    directed('{s:1'b1, co:1'b0, es:8'h80, ms:28'h0400000}, 8'h7C, 23'h0, 1'b0, 1'b0);
    directed('{s:1'b0, co:1'b0, es:8'h80, ms:28'h4000004}, 8'h80, 23'h0, 1'b0, 1'b0);
    directed('{s:1'b1, co:1'b0, es:8'h80, ms:28'h400000C}, 8'h80, 23'h000002, 1'b0, 1'b0);
    directed('{s:1'b0, co:1'b0, es:8'h80, ms:28'h7FFFFFC}, 8'h81, 23'h0, 1'b0, 1'b0);
    directed('{s:1'b1, co:1'b1, es:8'h7F, ms:28'h8000000}, 8'h80, 23'h0, 1'b0, 1'b0);
    directed('{s:1'b1, co:1'b1, es:8'hFE, ms:28'h8000000}, 8'hFF, 23'h0, 1'b1, 1'b0);
    directed('{s:1'b0, co:1'b0, es:8'h03, ms:28'h0100000}, 8'h00, 23'h080000, 1'b0, 1'b0);
    directed('{s:1'b1, co:1'b0, es:8'h03, ms:28'h0000000}, 8'h00, 23'h0, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) stim_q.push_back(rand_word());
    run_stream(60, 1);

    for (int i = 0; i < 200; i++) stim_q.push_back(rand_word());
    run_stream(3000, 0);

    reset_mid();

    for (int i = 0; i < 20; i++) stim_q.push_back(rand_word());
    run_stream(400, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_norm_pipe.md
FP_NORM_PIPE -- requirements
Module: fp_norm_pipe

Interface
REQ-001 SHALL have parameters: EW, default 8, exponent width; MW, default 23, stored-fraction width; MSW = MW+5 (derived, not overridable).
REQ-002 SHALL have ports (clock and reset first):
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts input this cycle.
- sign_in  input  1  result sign, passed through unchanged.
- co  input  1  adder carry-out.
- es  input  EW  pre-normalisation biased exponent.
- ms  input  MSW  bit MSW-1 carry, bit MW+3 hidden, bits MW+2:3 fraction, bits 2:0 guard/round/sticky.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sign_out  output  1  registered sign.
- e  output  EW  normalised biased exponent.
- m  output  MW  rounded stored fraction.
- ovf  output  1  result saturated to infinity.
- zero  output  1  result is exact zero.

Function
REQ-003 SHALL be a two-stage pipeline: S1 normalise, S2 round; each stage holds a valid bit.
REQ-004 SHALL transfer input when in_valid&&in_ready and output when out_valid&&out_ready.
REQ-005 SHALL have latency 2 cycles from accepted input to out_valid when unstalled, and throughput 1 word/cycle.
REQ-006 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready (S1 advances into S2 when S2 empties or is consumed the same cycle).
REQ-007 SHALL hold S2 registers and outputs stable while out_valid && !out_ready.
REQ-008 SHALL preserve order; no word dropped or duplicated under any stall pattern.
REQ-009 S1, co=1: SHALL shift ms right 1 with bit 0 = old bit1|old bit0 (sticky), exponent es+1.
REQ-010 S1, co=0: SHALL count leading zeros lz over ms[MW+3:0] (lz = MW+4 when all zero).
REQ-011 S1: if es > lz, SHALL shift left by lz and set exponent es-lz.
REQ-012 S1: if es <= lz (subnormal), SHALL shift left by max(es-1,0) and set exponent 0.
REQ-013 S1: ms[MW+3:0]==0 and co=0 SHALL produce e=0, m=0, zero=1.
REQ-014 S2 SHALL round to nearest, ties to even: increment when G && (R||S||LSB), LSB = fraction bit 3.
REQ-015 S2: fraction increment carrying out of the hidden bit SHALL give m=0, e+1.
REQ-016 S2: subnormal (exponent 0) whose rounding sets the hidden bit SHALL give e=1.
REQ-017 SHALL saturate any final exponent >= 2^EW-1 to e=all ones, m=0, ovf=1; ovf=0 otherwise.
REQ-018 SHALL pass sign_in to sign_out aligned with its word, including zero and overflow results.

Reset
REQ-019 With rst high at a clock edge, SHALL clear both valid bits, giving out_valid=0 and e, m, sign_out, ovf, zero all 0.
REQ-020 SHALL assert in_ready=1 in the first cycle after rst deasserts.
REQ-021 Reset mid-operation SHALL discard all in-flight words; none appear afterwards.
REQ-022 Reset SHALL take priority over a simultaneous handshake.

Verification (EW=8, MW=23, MSW=28)
REQ-023 es=8'h80, co=0, ms=28'h4000000 -> e=8'h80, m=0; ms=28'h0400000 -> e=8'h7C, m=0; both 2 cycles after acceptance.
REQ-024 Ties: es=8'h80, ms=28'h4000004 -> m=0 (tie, LSB 0); ms=28'h400000C -> m=23'h000002; ms=28'h7FFFFFC -> e=8'h81, m=0.
REQ-025 Carry and overflow: co=1, es=8'h7F, ms=28'h8000000 -> e=8'h80, m=0; co=1, es=8'hFE -> e=8'hFF, m=0, ovf=1.
REQ-026 Subnormal and zero: es=8'h03, ms=28'h0100000 -> e=0, m=23'h080000; ms=0 -> e=0, m=0, zero=1.
REQ-027 Backpressure: stream 4 words with out_ready=0 for 3 cycles -> in_ready falls once both stages are full; all 4 outputs appear in order after out_ready rises, each held stable while stalled.
REQ-028 Reset with 2 words in flight -> out_valid=0 next cycle; neither word is ever output.
